instr_fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the instruction decoder/controller.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words with their PC in a small prefetch FIFO and presents one instruction per cycle to decode under a valid/ready handshake.
- Handles redirects from branch/jal/jalr resolution by flushing the FIFO and squashing in-flight responses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; the head entry is presented combinationally.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type entry_t = logic [31:0],
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   output entry_t        head,
   output logic [CW-1:0] count
);

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: count_q gates every read.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   overflow_chk: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush && count_q == CW'(DEPTH)))
      else $error("fetch_fifo overflow");

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, redirect squash, prefetch FIFO to decode.
// Optional FETCH_STATS_EN adds pop and bubble counters.
module instr_fetch_unit
   import fetch_pkg::XLEN, fetch_pkg::fetch_entry_t;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instruction,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]     stat_fetched,
   output logic [31:0]     stat_bubbles
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

   logic [XLEN-1:0] pc_q, ret_pc_q;
   logic [CW-1:0]   outstanding_q, discard_q;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    head, push_entry;
   logic            req_fire, rsp_accept, push, pop;

   // Buffered plus in-flight words may never exceed the FIFO capacity.
   assign imem_req_valid = !rst && !redirect_valid &&
                           (({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDITS);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding (e.g. straggler across reset) is ignored.
   assign rsp_accept = imem_rsp_valid && (outstanding_q != '0);
   assign push       = rsp_accept && !redirect_valid && (discard_q == '0);
   assign push_entry = '{instr: imem_rsp_data, pc: ret_pc_q};

   assign if_valid       = (fifo_count != '0);
   assign pop            = if_valid && id_ready && !redirect_valid;
   assign if_instruction = if_valid ? head.instr : NOP_INSTR;
   assign if_pc          = if_valid ? head.pc : '0;
   assign if_pc_plus4    = if_pc + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC & ~32'h3;
         ret_pc_q      <= RESET_PC & ~32'h3;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         outstanding_q <= outstanding_q + CW'(req_fire) - CW'(rsp_accept);
         if (redirect_valid) begin
            pc_q      <= redirect_pc & ~32'h3;
            ret_pc_q  <= redirect_pc & ~32'h3;
            discard_q <= outstanding_q - CW'(rsp_accept);
         end else begin
            if (req_fire) pc_q <= pc_q + 32'd4;
            if (push) ret_pc_q <= ret_pc_q + 32'd4;
            if (rsp_accept && discard_q != '0) discard_q <= discard_q - CW'(1);
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_fetched <= '0;
         stat_bubbles <= '0;
      end else begin
         if (pop) stat_fetched <= stat_fetched + 32'd1;
         if (id_ready && !if_valid && !redirect_valid) stat_bubbles <= stat_bubbles + 32'd1;
      end
   end
`endif

endmodule
